// File: rtl/bus_pkg.sv
// Shared definitions for the two-requester bus arbiter: state encoding, bus
// width defaults and the memory-mapped IO port addresses.
package bus_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 8;

   localparam logic [9:0] INPUT_PORT  = 10'h3FE;
   localparam logic [9:0] OUTPUT_PORT = 10'h3FF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      ACK    = 2'd3
   } state_t;

endpackage

// File: rtl/bus_arb_pick.sv
// Two-way arbitration: one-hot winner, ptr_i selects who wins a tie.
// Purely combinational; no backpressure of its own.
module bus_arb_pick (
   input  logic       req0_i,
   input  logic       req1_i,
   input  logic       ptr_i,
   output logic [1:0] win_o
);

   always_comb begin
      win_o = 2'b00;
      if (req0_i && req1_i) begin
         win_o = ptr_i ? 2'b10 : 2'b01;
      end else if (req0_i) begin
         win_o = 2'b01;
      end else if (req1_i) begin
         win_o = 2'b10;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one memory/IO bus between CPU (0) and port poller (1); ack 3 cycles after req.
// Requesters hold req until ack. BUS_ARB_ROUND_ROBIN_EN selects round-robin ties, else port 0 wins.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              bus_write_en,
   output logic              bus_read_en,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata
);

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                ptr;
   logic [1:0]          win;

`ifdef BUS_ARB_ROUND_ROBIN_EN
   logic ptr_q, ptr_d;
   assign ptr = ptr_q;
`else
   assign ptr = 1'b0;
`endif

   bus_arb_pick u_pick (
      .req0_i (req0),
      .req1_i (req1),
      .ptr_i  (ptr),
      .win_o  (win)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
         ptr_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         // ACK re-arbitrates so a held request goes straight back to ACCESS.
         IDLE, ACK: begin
            if (win != 2'b00) begin
               state_d = ACCESS;
               owner_d = win[1];
               we_d    = win[0] ? we0    : we1;
               addr_d  = win[0] ? addr0  : addr1;
               wdata_d = win[0] ? wdata0 : wdata1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
               ptr_d   = win[0];
`endif
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: state_d = WAIT;
         WAIT: begin
            state_d = ACK;
            if (!we_q) begin
               rdata_d = bus_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt0         = (state_q != IDLE) && !owner_q;
      gnt1         = (state_q != IDLE) &&  owner_q;
      ack0         = (state_q == ACK)  && !owner_q;
      ack1         = (state_q == ACK)  &&  owner_q;
      bus_write_en = (state_q == ACCESS) &&  we_q;
      bus_read_en  = (state_q == ACCESS) && !we_q;
      bus_addr     = '0;
      bus_wdata    = '0;
      if (state_q == ACCESS || state_q == WAIT) begin
         bus_addr  = addr_q;
         bus_wdata = wdata_q;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a small memory/IO-port responder model.
module tb_bus_arbiter;
   import bus_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1, we0, we1;
   logic [9:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, ack0, ack1;
   logic [7:0] rdata;
   logic       bus_write_en, bus_read_en;
   logic [9:0] bus_addr;
   logic [7:0] bus_wdata;
   logic [7:0] bus_rdata;

   logic [7:0] mem [0:1023];
   logic [3:0] in_port  = 4'b1100;
   logic [3:0] out_port = 4'h0;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       own;
      logic       we;
      logic [9:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      logic [3:0] exp_out;
   } vec_t;

   vec_t vecs [8];

   bus_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0         (req0),
      .req1         (req1),
      .we0          (we0),
      .we1          (we1),
      .addr0        (addr0),
      .addr1        (addr1),
      .wdata0       (wdata0),
      .wdata1       (wdata1),
      .gnt0         (gnt0),
      .gnt1         (gnt1),
      .ack0         (ack0),
      .ack1         (ack1),
      .rdata        (rdata),
      .bus_write_en (bus_write_en),
      .bus_read_en  (bus_read_en),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_rdata    (bus_rdata)
   );

   always #5 clk = ~clk;

   // Responder: input port reads as {1111, in_port}, output port latches the low nibble.
   always @(posedge clk) begin
      if (bus_write_en) begin
         if (bus_addr == OUTPUT_PORT) out_port <= bus_wdata[3:0];
         else if (bus_addr != INPUT_PORT) mem[bus_addr] <= bus_wdata;
      end
      if (bus_read_en) begin
         if (bus_addr == INPUT_PORT)       bus_rdata <= {4'hF, in_port};
         else if (bus_addr == OUTPUT_PORT) bus_rdata <= {4'h0, out_port};
         else                              bus_rdata <= mem[bus_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [1:0] own_oh;
      own_oh = v.own ? 2'b10 : 2'b01;
      req0 = !v.own;
      req1 = v.own;
      if (v.own) begin
         we1 = v.we;  addr1 = v.addr;  wdata1 = v.wdata;
         we0 = !v.we; addr0 = ~v.addr; wdata0 = ~v.wdata;
      end else begin
         we0 = v.we;  addr0 = v.addr;  wdata0 = v.wdata;
         we1 = !v.we; addr1 = ~v.addr; wdata1 = ~v.wdata;
      end
      @(negedge clk);
      check($sformatf("v%0d_strobes", idx), {bus_write_en, bus_read_en}, v.we ? 2'b10 : 2'b01);
      check($sformatf("v%0d_gnt", idx), {gnt1, gnt0}, own_oh);
      check($sformatf("v%0d_addr", idx), bus_addr, v.addr);
      if (v.we) check($sformatf("v%0d_wdata", idx), bus_wdata, v.wdata);
      @(negedge clk);
      check($sformatf("v%0d_wait_strobes", idx), {bus_write_en, bus_read_en}, 2'b00);
      check($sformatf("v%0d_wait_addr", idx), bus_addr, v.addr);
      check($sformatf("v%0d_wait_ack", idx), {ack1, ack0}, 2'b00);
      @(negedge clk);
      check($sformatf("v%0d_ack", idx), {ack1, ack0}, own_oh);
      check($sformatf("v%0d_ack_bus", idx), {bus_addr, bus_wdata}, 18'h0);
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_idle", idx), {gnt1, gnt0, ack1, ack0}, 4'h0);
      check($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
      check($sformatf("v%0d_out_port", idx), out_port, v.exp_out);
   endtask

   initial begin
      logic [3:0] exp_own;
      vecs[0] = '{1'b0, 1'b0, 10'h3FE, 8'h00, 8'hFC, 4'h0};
      vecs[1] = '{1'b1, 1'b1, 10'h3FF, 8'h8C, 8'hFC, 4'hC};
      vecs[2] = '{1'b0, 1'b1, 10'h010, 8'hA5, 8'hFC, 4'hC};
      vecs[3] = '{1'b1, 1'b0, 10'h010, 8'h00, 8'hA5, 4'hC};
      vecs[4] = '{1'b0, 1'b1, 10'h3FE, 8'h33, 8'hA5, 4'hC};
      vecs[5] = '{1'b1, 1'b0, 10'h3FF, 8'h00, 8'h0C, 4'hC};
      vecs[6] = '{1'b1, 1'b1, 10'h000, 8'h5A, 8'h0C, 4'hC};
      vecs[7] = '{1'b0, 1'b0, 10'h000, 8'h00, 8'h5A, 4'hC};

      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      #1;
      check("reset_ctrl", {gnt1, gnt0, ack1, ack0, bus_write_en, bus_read_en}, 6'h0);
      check("reset_bus", {bus_addr, bus_wdata}, 18'h0);
      check("reset_rdata", rdata, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Both requesters held for four back-to-back reads, pointer freshly reset.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      exp_own = 4'b1010;
`else
      exp_own = 4'b0000;
`endif
      req0 = 1'b1; we0 = 1'b0; addr0 = 10'h010;
      req1 = 1'b1; we1 = 1'b0; addr1 = 10'h000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("b2b%0d_read_en", i), bus_read_en, 1'b1);
         check($sformatf("b2b%0d_gnt", i), {gnt1, gnt0}, exp_own[i] ? 2'b10 : 2'b01);
         @(negedge clk);
         check($sformatf("b2b%0d_wait_strobe", i), bus_read_en, 1'b0);
         @(negedge clk);
         check($sformatf("b2b%0d_ack", i), {ack1, ack0}, exp_own[i] ? 2'b10 : 2'b01);
         check($sformatf("b2b%0d_ack_strobe", i), bus_read_en, 1'b0);
         if (i == 3) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
      end
      @(negedge clk);
      check("b2b_idle_gnt", {gnt1, gnt0}, 2'b00);
      check("b2b_rdata", rdata, exp_own[3] ? 8'h5A : 8'hA5);

      // Reset asserted while the access sits in WAIT.
      req0 = 1'b1; we0 = 1'b0; addr0 = INPUT_PORT;
      @(negedge clk);
      check("rst_access_read_en", bus_read_en, 1'b1);
      @(negedge clk);
      check("rst_wait_gnt", gnt0, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_wait_ctrl", {gnt1, gnt0, ack1, ack0, bus_write_en, bus_read_en}, 6'h0);
      check("rst_wait_bus", {bus_addr, bus_wdata}, 18'h0);
      check("rst_wait_rdata", rdata, 8'h00);
      req0 = 1'b0;
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_no_ack", {ack1, ack0, gnt1, gnt0}, 4'h0);

      // Re-request after reset, then drop req0 during WAIT.
      req0 = 1'b1; we0 = 1'b0; addr0 = INPUT_PORT;
      @(negedge clk);
      check("drop_read_en", bus_read_en, 1'b1);
      @(negedge clk);
      req0 = 1'b0;
      @(negedge clk);
      check("drop_ack0", {ack1, ack0}, 2'b01);
      @(negedge clk);
      check("drop_idle_gnt", {gnt1, gnt0, ack1, ack0}, 4'h0);
      check("drop_idle_addr", bus_addr, 10'h000);
      check("drop_rdata", rdata, 8'hFC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, address width of the shared memory/IO bus.
REQ-002 Parameter DATA_W, default 8, data width of the shared bus.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0, req1  input  1 each  access request from requester 0 (CPU) and 1 (port poller).
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; valid while reqN high.
REQ-007 addr0, addr1  input  ADDR_W each  target address, including 10'h3FE input port and 10'h3FF output port.
REQ-008 wdata0, wdata1  input  DATA_W each  write data.
REQ-009 gnt0, gnt1  output  1 each  high while requester N owns the bus (ACCESS..ACK).
REQ-010 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-011 rdata  output  DATA_W  read data captured for the last completed read.
REQ-012 bus_write_en, bus_read_en  output  1 each  shared bus strobes.
REQ-013 bus_addr  output  ADDR_W, bus_wdata  output  DATA_W  shared bus address and data.
REQ-014 bus_rdata  input  DATA_W  data returned by memory/io_ports.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS, WAIT and ACK.
REQ-016 IDLE: any reqN high at an edge SHALL select a winner, latch its we/addr/wdata and enter ACCESS.
REQ-017 ACCESS: exactly one strobe high (bus_write_en if latched we=1, else bus_read_en) for exactly one cycle; next state WAIT.
REQ-018 WAIT: strobes low, bus_addr/bus_wdata held; the end-of-WAIT edge SHALL capture bus_rdata into rdata on reads only; next state ACK.
REQ-019 ACK: ackN high one cycle for the owner; at the end of ACK, arbitrate as in IDLE (back-to-back allowed, next ACCESS directly) else go to IDLE.
REQ-020 Latency: req sampled at edge k -> strobe in cycle k+1 -> ack in cycle k+3; throughput one access per 3 cycles.
REQ-021 Requester SHALL hold reqN and operands until ack; reqN still high in its ACK cycle counts as a new request.
REQ-022 reqN dropped mid-transaction SHALL NOT abort it; the latched access completes and ack still pulses.
REQ-023 At most one gntN high at any time; gnt and ack SHALL never go to a non-requesting requester.
REQ-024 Outside ACCESS..WAIT, bus_addr and bus_wdata SHALL be 0.
REQ-025 Address is not decoded; writes to 10'h3FE and reads of 10'h3FF pass through unchanged.
REQ-026 rdata SHALL hold its value across writes and idle cycles.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, all gnt/ack/strobes 0, bus_addr 0, bus_wdata 0, rdata 0, priority pointer to requester 0.
REQ-028 Reset mid-transaction SHALL drop it with no ack; the requester re-requests after release.

Configuration
REQ-029 With BUS_ARB_ROUND_ROBIN_EN defined, on simultaneous requests the requester not granted last SHALL win (pointer toggles on each grant).
REQ-030 Without BUS_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win simultaneous requests (fixed priority).

Structure
REQ-031 Shared package bus_pkg SHALL hold the state encoding, ADDR_W/DATA_W defaults, and INPUT_PORT (10'h3FE) / OUTPUT_PORT (10'h3FF) constants.
REQ-032 Arbitration SHALL be a sub-module bus_arb_pick (req0, req1, pointer -> one-hot winner); the FSM and bus muxing stay in bus_arbiter.

Verification
REQ-033 req0=1 we0=0 addr0=10'h3FE, io_ports in_port=4'b1100 -> bus_read_en in cycle k+1, ack0 in k+3, rdata=8'b11111100.
REQ-034 req1=1 we1=1 addr1=10'h3FF wdata1=8'b10001100 -> bus_write_en one cycle, ack1 in k+3, io_ports out_port=4'b1100, rdata unchanged.
REQ-035 req0 and req1 high together, held 4 accesses -> with macro: grants alternate 0,1,0,1; without macro: 0,0,0,0 while req0 stays high.
REQ-036 rst_n low during WAIT -> strobes and gnt 0 immediately, no ack, state IDLE, rdata 0.
REQ-037 req0 dropped in WAIT cycle -> ack0 still pulses in k+3, then IDLE with bus_addr 0.
REQ-038 req0 held through ACK -> next bus_read_en exactly 3 cycles after the previous one, no IDLE cycle.
